// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side FWFT byte buffer behind the UART receiver
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 8,
    parameter int ALMOST_FULL = 12
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       wr_valid_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    input  logic                       rd_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       almost_full_o,
    output logic                       overrun_o,
    input  logic                       clear_overrun_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_AF   = LW'(ALMOST_FULL);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // Storage is deliberately left unreset; level gates what is visible.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          overrun;

    logic is_empty;
    logic is_full;
    logic rd_fire;
    logic wr_fire;
    logic wr_drop;

    // Pointers alone cannot tell full from empty once they wrap; level can.
    assign is_empty = (level == '0);
    assign is_full  = (level == LEVEL_FULL);

    // A read only happens when something is already stored, so an empty
    // buffer never bypasses an incoming byte straight to the consumer.
    assign rd_fire = !is_empty && rd_ready_i;

    // A full buffer still takes a byte if the oldest one leaves this cycle.
    assign wr_fire = wr_valid_i && (!is_full || rd_fire);
    assign wr_drop = wr_valid_i && !wr_fire;

    // Capture accepted bytes at the write pointer.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Advance the write pointer once per accepted byte, wrapping naturally.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Advance the read pointer once per byte handed to the consumer.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_ptr <= '0;
        end else if (rd_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Track occupancy; a simultaneous write and read leave it unchanged.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            level <= '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Sticky overrun; a fresh drop wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overrun <= 1'b0;
        end else if (wr_drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun_i) begin
            overrun <= 1'b0;
        end
    end

    // All status derives from the level register, so reset clears the
    // outputs immediately without waiting for a clock edge.
    assign rd_valid_o    = !is_empty;
    assign rd_data_o     = is_empty ? '0 : mem[rd_ptr];
    assign level_o       = level;
    assign almost_full_o = (level >= LEVEL_AF);
    assign overrun_o     = overrun;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each single-cycle valid/byte strobe from the receiver into a circular buffer and presents the bytes first-word-fall-through to a consumer over a valid/ready handshake. It absorbs consumer stalls, reports fill level and a programmable high-water flag, and records a sticky overrun when a byte arrives with the buffer full.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
WIDTH, 8, data width in bits
ALMOST_FULL, 12, almost_full_o asserts when level >= this value; range 1..DEPTH

Ports:
clk_i  input  1  system clock, all logic on rising edge
reset_ni  input  1  asynchronous active-low reset
wr_valid_i  input  1  write strobe from UART receiver valid output
wr_data_i  input  WIDTH  byte from UART receiver; sampled when wr_valid_i=1
rd_valid_o  output  1  buffer non-empty; rd_data_o holds oldest byte
rd_data_o  output  WIDTH  oldest byte; forced to 0 when rd_valid_o=0
rd_ready_i  input  1  consumer accepts rd_data_o when rd_valid_o=1
level_o  output  $clog2(DEPTH)+1  current number of stored bytes, 0..DEPTH
almost_full_o  output  1  level_o >= ALMOST_FULL
overrun_o  output  1  sticky: a byte was dropped because buffer was full
clear_overrun_i  input  1  synchronous clear of overrun_o

Behaviour:
- Reset (reset_ni=0, asynchronous assert): write pointer, read pointer, level -> 0; rd_valid_o=0, rd_data_o=0, almost_full_o=0, overrun_o=0. Storage array not reset. Reset mid-operation discards all contents immediately; buffered bytes are never presented after release.
- Write accept: wr_valid_i=1 and (level<DEPTH or read accepted same cycle) -> wr_data_i stored at write pointer, write pointer += 1 mod DEPTH.
- Read accept: rd_valid_o=1 and rd_ready_i=1 -> read pointer += 1 mod DEPTH.
- Level: +1 on write-only, -1 on read-only, unchanged on simultaneous write+read or neither. Pointers are $clog2(DEPTH) bits and wrap naturally; level disambiguates full vs empty.
- Latency: byte written at edge N is visible on rd_data_o with rd_valid_o=1 after edge N (first-word-fall-through, one cycle write-to-read). No same-cycle bypass: when empty, a concurrent rd_ready_i has no effect, and the write still lands.
- rd_valid_o = (level != 0); rd_data_o = storage[read pointer] when rd_valid_o=1, else 0. rd_data_o is stable while rd_valid_o=1 and rd_ready_i=0, including across incoming writes.
- Full + write + read same cycle: read retires oldest entry, write accepted, level stays DEPTH, no overrun.
- Full + write, no read: byte dropped, contents and pointers unchanged, overrun_o set on next edge.
- overrun_o: set takes priority over clear_overrun_i in the same cycle; otherwise clear_overrun_i=1 -> 0 next edge; otherwise holds.
- almost_full_o and level_o are registered/derived from the level register, so they update on the same edge as the pointers.
- wr_valid_i held high for several cycles writes once per cycle. The UART receiver emits single-cycle strobes; no edge detection is performed here.

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 on separate cycles with rd_ready_i=0 -> level_o=3, rd_valid_o=1, rd_data_o=0x41. Then rd_ready_i=1 for 3 cycles -> rd_data_o reads 0x41, 0x42, 0x43, level_o=0, rd_valid_o=0, rd_data_o=0.
- Write 16 bytes 0x00..0x0F with no reads -> level_o=16, almost_full_o=1 from the 12th write onward. A 17th write of 0xFF -> overrun_o=1, level_o=16. Drain 16 -> data 0x00..0x0F in order; 0xFF never appears.
- Buffer full, simultaneous write 0xA5 and read -> level_o stays 16, overrun_o stays 0, 0xA5 read out last after draining.
- overrun_o=1, assert clear_overrun_i alone -> overrun_o=0 next cycle. Repeat with clear_overrun_i coincident with a full-buffer write -> overrun_o remains 1.
- Empty buffer, wr_valid_i=1 (0x5A) with rd_ready_i=1 same cycle -> no read occurs. Next cycle rd_valid_o=1, rd_data_o=0x5A, level_o=1.
- Level 5 with pointers wrapped past index 15, assert reset_ni=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, a write of 0x11 reads back as 0x11 with level_o=1.
